// File: rtl/ifetch_mt_pkg.sv
// ============================================================================
// ifetch_mt_pkg : shared state encodings and lane packing helper for ifetch_mt
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ifetch_mt_pkg;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_OPC   = 3'd1;
   localparam state_t S_ARG   = 3'd2;
   localparam state_t S_PUSH  = 3'd3;
   localparam state_t S_JWAIT = 3'd4;

   // Operand byte 0 sits in the most significant lane, right below the decoded word.
   function automatic int lane_lsb(input int lane, input int max_ops);
      return (max_ops - 1 - lane) * 8;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_mt_pc_table.sv
// ============================================================================
// ifetch_mt_pc_table : saved PC per (channel,thread), async read, one write port
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ifetch_mt_pc_table #(
   parameter int IDX_W = 4,
   parameter int PC_W  = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [PC_W-1:0]  rd_pc,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [PC_W-1:0]  wr_pc
);

   logic [PC_W-1:0] pc_mem [2**IDX_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            pc_mem[i] <= '0;
         end
      end else if (wr_en) begin
         pc_mem[wr_idx] <= wr_pc;
      end
   end

   assign rd_pc = pc_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/ifetch_mt.sv
// ============================================================================
// ifetch_mt : multi-channel multi-thread instruction fetch (opcode + operands)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ifetch_mt
   import ifetch_mt_pkg::*;
#(
   parameter int CHAN_W  = 3,
   parameter int THR_W   = 1,
   parameter int PC_W    = 12,
   parameter int INSN_W  = 24,
   parameter int MAX_OPS = 2,
   parameter int OPC_W   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHAN_W-1:0]         next_task_channel,
   input  logic [THR_W-1:0]          next_task_thread,
   input  logic                      next_task_ready,
   output logic                      next_task_ack,
   input  logic [PC_W-1:0]           jump_target,
   input  logic                      jump_enable,
   output logic [CHAN_W+PC_W-1:0]    mem_addr,
   output logic                      mem_rd_en,
   input  logic [7:0]                mem_d_in,
   input  logic                      mem_ack,
   output logic [7:0]                opcode,
   input  logic [INSN_W-1:0]         decoded_insn,
   input  logic [OPC_W-1:0]          operand_count,
   input  logic                      insn_noop,
   input  logic                      insn_suspend,
   input  logic                      insn_pull,
   input  logic                      insn_jump,
   output logic                      pull_decoded,
   output logic [INSN_W+8*MAX_OPS-1:0] ififo_di,
   output logic                      ififo_shift,
   input  logic                      ififo_full,
   output logic                      task_done
);

   localparam int LANES_W = 8 * MAX_OPS;
   localparam int IDX_W   = CHAN_W + THR_W;

   state_t              state;
   state_t              state_nx;
   logic [CHAN_W-1:0]   chan;
   logic [THR_W-1:0]    thr;
   logic [PC_W-1:0]     pc;
   logic [PC_W-1:0]     jump_pc_saved;
   logic                jump_held;
   logic [INSN_W-1:0]   dec;
   logic [LANES_W-1:0]  lanes;
   logic [OPC_W-1:0]    op_cnt;
   logic [OPC_W-1:0]    lane_idx;
   logic                f_noop;
   logic                f_suspend;
   logic                f_pull;
   logic                f_jump;
   logic [PC_W-1:0]     table_pc;

   logic                fetch_active;
   logic                fetch_ack;
   logic                last_arg;
   logic                push_pending;
   logic                push_blocked;
   logic                push_leave;
   logic                redirect;
   logic                writeback;
   logic [OPC_W-1:0]    cnt_clamped;

   ifetch_mt_pc_table #(
      .IDX_W (IDX_W),
      .PC_W  (PC_W)
   ) u_pc_table (
      .clk    (clk),
      .reset  (reset),
      .rd_idx ({next_task_channel, next_task_thread}),
      .rd_pc  (table_pc),
      .wr_en  (writeback),
      .wr_idx ({chan, thr}),
      .wr_pc  (pc)
   );

   // A jump always beats a same-cycle fetch acknowledge.
   always_comb begin
      cnt_clamped  = (operand_count > OPC_W'(MAX_OPS)) ? OPC_W'(MAX_OPS) : operand_count;
      fetch_active = (state == S_OPC) || (state == S_ARG);
      fetch_ack    = fetch_active && mem_ack && !jump_enable;
      last_arg     = (lane_idx == op_cnt - 1'b1);
      push_pending = (state == S_PUSH) && !f_noop;
      push_blocked = push_pending && ififo_full;
      push_leave   = (state == S_PUSH) && !push_blocked;
      redirect     = push_leave && (jump_enable || jump_held);
      writeback    = push_leave && !redirect && f_suspend;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (next_task_ready) state_nx = S_OPC;
         end
         S_OPC: begin
            if (jump_enable) begin
               state_nx = S_OPC;
            end else if (mem_ack) begin
               state_nx = (cnt_clamped != '0) ? S_ARG : S_PUSH;
            end
         end
         S_ARG: begin
            if (jump_enable) begin
               state_nx = S_OPC;
            end else if (mem_ack && last_arg) begin
               state_nx = S_PUSH;
            end
         end
         S_PUSH: begin
            if (push_leave) begin
               if (redirect)       state_nx = S_OPC;
               else if (f_suspend) state_nx = S_IDLE;
               else if (f_jump)    state_nx = S_JWAIT;
               else                state_nx = S_OPC;
            end
         end
         S_JWAIT: begin
            if (jump_enable) state_nx = S_OPC;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      next_task_ack = (state == S_IDLE) && next_task_ready;
      mem_rd_en     = fetch_active && !jump_enable;
      mem_addr      = {chan, pc};
      opcode        = ((state == S_OPC) && fetch_ack) ? mem_d_in : 8'h00;
      ififo_shift   = push_pending && !ififo_full;
      ififo_di      = {dec, lanes};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chan          <= '0;
         thr           <= '0;
         pc            <= '0;
         jump_pc_saved <= '0;
         jump_held     <= 1'b0;
         dec           <= '0;
         lanes         <= '0;
         op_cnt        <= '0;
         lane_idx      <= '0;
         f_noop        <= 1'b0;
         f_suspend     <= 1'b0;
         f_pull        <= 1'b0;
         f_jump        <= 1'b0;
         task_done     <= 1'b0;
         pull_decoded  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (next_task_ready) begin
                  chan      <= next_task_channel;
                  thr       <= next_task_thread;
                  pc        <= table_pc;
                  jump_held <= 1'b0;
               end
            end
            S_OPC: begin
               if (jump_enable) begin
                  pc <= jump_target;
               end else if (mem_ack) begin
                  dec       <= decoded_insn;
                  op_cnt    <= cnt_clamped;
                  f_noop    <= insn_noop;
                  f_suspend <= insn_suspend;
                  f_pull    <= insn_pull;
                  f_jump    <= insn_jump;
                  lanes     <= '0;
                  lane_idx  <= '0;
                  pc        <= pc + 1'b1;
               end
            end
            S_ARG: begin
               if (jump_enable) begin
                  pc <= jump_target;
               end else if (mem_ack) begin
                  for (int i = 0; i < MAX_OPS; i++) begin
                     if (lane_idx == OPC_W'(i)) lanes[lane_lsb(i, MAX_OPS) +: 8] <= mem_d_in;
                  end
                  lane_idx <= lane_idx + 1'b1;
                  pc       <= pc + 1'b1;
               end
            end
            S_PUSH: begin
               // A jump arriving while the push is stalled is parked until the push lands.
               if (push_blocked) begin
                  if (jump_enable) begin
                     jump_held     <= 1'b1;
                     jump_pc_saved <= jump_target;
                  end
               end else if (jump_enable) begin
                  pc        <= jump_target;
                  jump_held <= 1'b0;
               end else if (jump_held) begin
                  pc        <= jump_pc_saved;
                  jump_held <= 1'b0;
               end
            end
            S_JWAIT: begin
               if (jump_enable) pc <= jump_target;
            end
            default: ;
         endcase
         task_done    <= writeback;
         pull_decoded <= push_leave && f_pull && !f_noop;
      end
   end

endmodule

`default_nettype wire
